// File: rtl/vga_line_fetcher.sv
// Shared video-RAM scheduler: prefetches upscaled framebuffer rows into ping-pong
// line buffers for the VGA output and serves game-logic pixel writes in idle cycles.
module vga_line_fetcher #(
  parameter int DATA_W   = 12,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SHIFT    = 2,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_sync,
  input  logic              available,
  input  logic [15:0]       pix_x,
  input  logic [15:0]       pix_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              underrun,
  output logic              fetch_busy
);

  localparam int COL_W   = $clog2(FB_W);
  localparam int ROW_W   = $clog2(FB_H);
  localparam int FB_SIZE = FB_W * FB_H;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [COL_W-1:0]    col_r, col_s, col_d_r, col_d_s;
  logic                rd_v_r, rd_v_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic [ROW_W-1:0]    back_row_r, back_row_s, front_row_r;
  logic                front_sel_r, swap_pending_r, set_pending_s;
  logic                vs_d_r, av_d_r;
  logic                vs_fall_s, av_fall_s, av_rise_s, busy_s, swap_s, wr_ok_s;
  logic                trig_s;
  logic [ROW_W-1:0]    trig_row_s;
  logic [ADDR_W-1:0]   trig_base_s;
  logic [16:0]         next_y_s, av_row_full_s;
  logic [15:0]         px_col_s;
  logic [COL_W-1:0]    disp_col_s;
  logic                disp_sel_s;
  logic [DATA_W-1:0]   line_buf [0:1][0:FB_W-1];

  assign vs_fall_s     = vs_d_r & ~v_sync;
  assign av_fall_s     = av_d_r & ~available;
  assign av_rise_s     = available & ~av_d_r;
  assign busy_s        = (state_r != IDLE);
  assign swap_s        = av_rise_s & swap_pending_r & ~busy_s;
  assign next_y_s      = {1'b0, pix_y} + 17'd1;
  assign av_row_full_s = next_y_s >> SHIFT;
  assign trig_base_s   = ADDR_W'(trig_row_s) * ADDR_W'(FB_W);
  assign wr_ok_s       = ({1'b0, wr_addr} < (ADDR_W + 1)'(FB_SIZE));
  // The swapping edge already shows the new front buffer.
  assign disp_sel_s    = front_sel_r ^ swap_s;

  // Fetch trigger decode; frame start always refetches row 0.
  always_comb begin
    trig_s     = 1'b0;
    trig_row_s = '0;
    if (vs_fall_s) begin
      trig_s     = 1'b1;
      trig_row_s = '0;
    end else if (av_fall_s && (next_y_s != 17'(V_ACTIVE)) &&
                 (av_row_full_s != 17'(front_row_r))) begin
      trig_s     = 1'b1;
      trig_row_s = av_row_full_s[ROW_W-1:0];
    end else begin
      trig_s     = 1'b0;
      trig_row_s = '0;
    end
  end

  // Display column clamps to the last framebuffer column.
  always_comb begin
    px_col_s = pix_x >> SHIFT;
    if (px_col_s >= 16'(FB_W)) begin
      disp_col_s = COL_W'(FB_W - 1);
    end else begin
      disp_col_s = px_col_s[COL_W-1:0];
    end
  end

  // Next-state and RAM port arbitration; the trigger cycle itself issues column 0.
  always_comb begin
    state_s       = state_r;
    col_s         = col_r;
    col_d_s       = col_d_r;
    rd_v_s        = 1'b0;
    base_s        = base_r;
    back_row_s    = back_row_r;
    set_pending_s = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    wr_ack        = 1'b0;
    if (!rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            mem_addr   = trig_base_s;
            rd_v_s     = 1'b1;
            col_d_s    = '0;
            col_s      = COL_W'(1);
            base_s     = trig_base_s;
            back_row_s = trig_row_s;
            state_s    = FETCH;
          end else if (wr_req) begin
            wr_ack    = 1'b1;
            mem_addr  = wr_addr;
            mem_we    = wr_ok_s;
            mem_wdata = wr_data;
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: begin
          mem_addr = base_r + ADDR_W'(col_r);
          rd_v_s   = 1'b1;
          col_d_s  = col_r;
          col_s    = col_r + COL_W'(1);
          if (col_r == COL_W'(FB_W - 1)) begin
            state_s = DRAIN;
          end else begin
            state_s = FETCH;
          end
        end
        DRAIN: begin
          state_s       = IDLE;
          set_pending_s = 1'b1;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      col_r          <= '0;
      col_d_r        <= '0;
      rd_v_r         <= 1'b0;
      base_r         <= '0;
      back_row_r     <= '0;
      front_row_r    <= '0;
      front_sel_r    <= 1'b0;
      swap_pending_r <= 1'b0;
      vs_d_r         <= 1'b0;
      av_d_r         <= 1'b0;
      underrun       <= 1'b0;
      fetch_busy     <= 1'b0;
      pix_rgb        <= '0;
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      col_d_r    <= col_d_s;
      rd_v_r     <= rd_v_s;
      base_r     <= base_s;
      back_row_r <= back_row_s;
      vs_d_r     <= v_sync;
      av_d_r     <= available;
      fetch_busy <= (state_s != IDLE);
      underrun   <= underrun | (busy_s & (trig_s | av_rise_s));
      if (swap_s) begin
        front_sel_r    <= ~front_sel_r;
        front_row_r    <= back_row_r;
        swap_pending_r <= 1'b0;
      end else if (set_pending_s) begin
        swap_pending_r <= 1'b1;
      end
      pix_rgb <= available ? line_buf[disp_sel_s][disp_col_s] : '0;
    end
  end

  // Read data lands one clock after its address; buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (rd_v_r && rst) begin
      line_buf[~front_sel_r][col_d_r] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Self-checking bench for vga_line_fetcher: table-driven line triggers, writer
// arbitration, reset and underrun sequences, plus randomized write/fetch/display rounds.
module tb_vga_line_fetcher;
  localparam int FB_W = 160, FB_SIZE = 19200;

  logic        clk = 1'b0;
  logic        rst, v_sync, available, wr_req, wr_ack, mem_we, underrun, fetch_busy;
  logic [15:0] pix_x, pix_y;
  logic [14:0] mem_addr, wr_addr;
  logic [11:0] mem_wdata, mem_rdata, wr_data, pix_rgb;

  always #5 clk = ~clk;

  vga_line_fetcher #(.DATA_W(12), .FB_W(160), .FB_H(120), .SHIFT(2),
                     .V_ACTIVE(480), .ADDR_W(15)) dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .available(available),
    .pix_x(pix_x), .pix_y(pix_y), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .pix_rgb(pix_rgb),
    .underrun(underrun), .fetch_busy(fetch_busy));

  // Video RAM: synchronous read-first, preloaded so mem[i] = i.
  logic [11:0] ram [0:32767];
  logic        preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 32768; i++) ram[i] = 12'(i);
      preloaded = 1'b1;
    end
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Reference: expected framebuffer contents and which row each buffer holds.
  logic [11:0] exp_ram [0:32767];
  int  front_m, pend_row;
  bit  pend_v;
  int  n_tests = 0, n_fail = 0;

  typedef struct { int y; bit fetch; int row; } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int exp_pix(input int row, input int px);
    int col;
    col = px / 4;
    if (col > FB_W - 1) col = FB_W - 1;
    return int'(exp_ram[row * FB_W + col]);
  endfunction

  // Trigger inputs are already driven for this cycle; checks every issued address.
  task automatic run_fetch(input int row, input string nm);
    int bad = 0;
    #1;
    if (int'(mem_addr) != row * FB_W || mem_we !== 1'b0 || wr_ack !== 1'b0 ||
        fetch_busy !== 1'b0) bad++;
    tick();
    for (int k = 1; k < FB_W; k++) begin
      #1;
      if (int'(mem_addr) != row * FB_W + k || mem_we !== 1'b0 || wr_ack !== 1'b0 ||
          fetch_busy !== 1'b1) bad++;
      tick();
    end
    #1;
    if (fetch_busy !== 1'b1 || mem_we !== 1'b0 || wr_ack !== 1'b0) bad++;
    tick();
    #1;
    if (fetch_busy !== 1'b0) bad++;
    check(nm, bad, 0);
    pend_row = row;
    pend_v   = 1'b1;
  endtask

  task automatic show_line(input int n);
    int px;
    px = int'($urandom_range(0, 700));
    available = 1'b1;
    pix_x     = 16'(px);
    if (pend_v) begin
      front_m = pend_row;
      pend_v  = 1'b0;
    end
    tick();
    #1;
    check("pix_line_start", int'(pix_rgb), exp_pix(front_m, px));
    for (int i = 1; i < n; i++) begin
      px    = int'($urandom_range(0, 700));
      pix_x = 16'(px);
      tick();
      #1;
      check("pix_random", int'(pix_rgb), exp_pix(front_m, px));
    end
  endtask

  task automatic line_end(input int y);
    pix_y     = 16'(y);
    available = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad, r, nw, wa, wd, wcol, px, wait_n;
    bit ok;

    tbl[0] = '{2,   1'b0, 0};
    tbl[1] = '{3,   1'b1, 1};
    tbl[2] = '{4,   1'b0, 0};
    tbl[3] = '{7,   1'b1, 2};
    tbl[4] = '{479, 1'b0, 0};
    tbl[5] = '{478, 1'b1, 119};
    tbl[6] = '{0,   1'b1, 0};
    tbl[7] = '{100, 1'b1, 25};

    for (int i = 0; i < 32768; i++) exp_ram[i] = 12'(i);
    front_m = 0; pend_row = 0; pend_v = 1'b0;

    rst = 1'b0; v_sync = 1'b1; available = 1'b0; pix_x = 16'd0; pix_y = 16'd0;
    wr_req = 1'b0; wr_addr = 15'd0; wr_data = 12'd0;
    @(negedge clk);
    repeat (3) tick();
    #1;
    check("reset_outputs", int'({mem_addr, mem_we, mem_wdata, wr_ack, pix_rgb, underrun, fetch_busy}), 0);

    // Reset in the middle of a fetch, with a writer waiting.
    rst = 1'b1;
    tick();
    v_sync = 1'b0; wr_req = 1'b1; wr_addr = 15'(FB_SIZE); wr_data = 12'h5A5;
    #1;
    check("trigger_beats_writer", int'({wr_ack, mem_we}), 0);
    repeat (20) tick();
    #1;
    check("busy_mid_fetch", int'(fetch_busy), 1);
    rst = 1'b0;
    tick();
    #1;
    check("reset_mid_fetch", int'({mem_addr, mem_we, mem_wdata, wr_ack, pix_rgb, underrun, fetch_busy}), 0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("oob_write_acked", int'({wr_ack, mem_we, mem_addr}), int'({1'b1, 1'b0, 15'(FB_SIZE)}));
    tick();
    wr_req = 1'b0;
    #1;
    check("ack_drops", int'(wr_ack), 0);

    // Frame start fetches row 0; pixel 8 maps to column 2.
    v_sync = 1'b1;
    tick();
    v_sync = 1'b0;
    run_fetch(0, "fetch_row0_vsync");
    available = 1'b1; pix_x = 16'd8;
    front_m = pend_row; pend_v = 1'b0;
    tick();
    #1;
    check("pix_x8", int'(pix_rgb), 2);
    show_line(3);

    foreach (tbl[i]) begin
      line_end(tbl[i].y);
      if (tbl[i].fetch) begin
        run_fetch(tbl[i].row, $sformatf("fetch_tbl%0d", i));
      end else begin
        bad = 0;
        #1;
        if (mem_addr !== 15'd0 || mem_we !== 1'b0 || fetch_busy !== 1'b0) bad++;
        tick();
        #1;
        if (fetch_busy !== 1'b0 || pix_rgb !== 12'd0) bad++;
        check($sformatf("nofetch_tbl%0d", i), bad, 0);
      end
      show_line(3);
    end

    // Writer starves during a fetch and is served right after DRAIN.
    wr_req = 1'b1; wr_addr = 15'd807; wr_data = 12'hABC;
    line_end(40);
    run_fetch(10, "fetch_starve");
    check("ack_after_drain", int'({wr_ack, mem_we, mem_addr, mem_wdata}),
          int'({1'b1, 1'b1, 15'd807, 12'hABC}));
    exp_ram[807] = 12'hABC;
    tick();
    wr_req = 1'b0;
    show_line(2);

    // Randomized rounds: writes into a row, fetch it, display it.
    for (int it = 0; it < 6; it++) begin
      if (it == 0) r = 5;
      else begin
        r = int'($urandom_range(1, 119));
        if (r == front_m) r = (r % 119) + 1;
      end
      wcol = (it == 0) ? 7 : 0;
      nw = int'($urandom_range(1, 6));
      for (int w = 0; w < nw; w++) begin
        ok = ($urandom_range(0, 4) != 0);
        if (ok) begin
          wcol = int'($urandom_range(0, FB_W - 1));
          wa   = r * FB_W + wcol;
        end else begin
          wa = int'($urandom_range(FB_SIZE, 32767));
        end
        wd = int'($urandom_range(0, 4095));
        wr_req = 1'b1; wr_addr = 15'(wa); wr_data = 12'(wd);
        #1;
        check("rand_write", int'({wr_ack, mem_we, mem_addr, mem_wdata}),
              int'({1'b1, ok, 15'(wa), 12'(wd)}));
        if (ok) exp_ram[wa] = 12'(wd);
        tick();
      end
      wr_req = 1'b0;
      line_end(4 * r - 1 + int'($urandom_range(0, 3)));
      run_fetch(r, "fetch_rand");
      show_line(2);
      px = wcol * 4 + int'($urandom_range(0, 3));
      pix_x = 16'(px);
      tick();
      #1;
      check("pix_written_col", int'(pix_rgb), exp_pix(front_m, px));
    end

    // av_rise 50 clocks after a trigger: no swap, sticky underrun.
    r = (front_m == 60) ? 61 : 60;
    line_end(4 * r - 1);
    repeat (50) tick();
    px = int'($urandom_range(0, 639));
    available = 1'b1; pix_x = 16'(px);
    tick();
    #1;
    check("underrun_set", int'(underrun), 1);
    check("old_row_on_underrun", int'(pix_rgb), exp_pix(front_m, px));
    wait_n = 0;
    while (fetch_busy === 1'b1 && wait_n < 300) begin
      tick();
      #1;
      wait_n++;
    end
    check("fetch_completes", int'(fetch_busy), 0);
    pend_row = r; pend_v = 1'b1;
    px = int'($urandom_range(0, 639));
    pix_x = 16'(px);
    repeat (3) tick();
    #1;
    check("old_row_after_fetch", int'(pix_rgb), exp_pix(front_m, px));
    check("underrun_sticky", int'(underrun), 1);

    rst = 1'b0;
    tick();
    #1;
    check("underrun_cleared", int'(underrun), 0);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_line_fetcher.md
Name: vga_line_fetcher

Overview:
- Schedules a shared single-port video RAM between two users: display line prefetch (high priority) and game-logic pixel writes (low priority).
- Holds a ping-pong pair of line buffers. The back buffer fills during blanking while the front buffer feeds the VGA output.
- Upscales a FB_W x FB_H framebuffer by 2^SHIFT in both axes. Timing inputs come from the VGA timing generator and are clk-synchronous.

Parameters:
- DATA_W, 12, pixel width (RGB444)
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- SHIFT, 2, log2 of the upscale factor
- V_ACTIVE, 480, active display lines
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- v_sync  in  1  timing-generator V_SYNC; its falling edge marks frame start
- available  in  1  active-video flag
- pix_x  in  16  current active pixel column
- pix_y  in  16  current active line
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after the address
- wr_req  in  1  writer request; held high until acked
- wr_addr  in  ADDR_W  writer linear address (row*FB_W + col)
- wr_data  in  DATA_W  writer pixel
- wr_ack  out  1  1-clk pulse; the write is accepted this cycle
- pix_rgb  out  DATA_W  pixel to the DAC; 0 outside active video
- underrun  out  1  sticky: a buffer swap was due before its fetch completed
- fetch_busy  out  1  high while in FETCH/DRAIN

Behaviour:
- Reset (rst==0 at posedge): FSM->IDLE.
  - Cleared to 0: all outputs, edge-detect registers, front_sel, swap_pending, front_row, back_row.
  - Line-buffer contents are not cleared.
  - Reset asserted mid-fetch aborts the fetch immediately; the next cycle issues no mem access.
- Edge detection: registered copies of v_sync and available give vs_fall, av_fall and av_rise as 1-clk pulses.
- Fetch triggers (evaluated in IDLE):
  - vs_fall: target row 0.
  - av_fall: next = pix_y+1; if next == V_ACTIVE there is no trigger; otherwise target = next>>SHIFT.
  - If target equals the row already in the front buffer, there is no trigger.
  - If vs_fall and av_fall occur in the same cycle, vs_fall wins.
- A trigger arriving while in FETCH/DRAIN: the trigger is dropped and underrun is set.
- FSM:
  - IDLE -> FETCH on trigger. On entry: base = target*FB_W, col = 0, back_row = target.
  - FETCH: each cycle, mem_addr = base+col, mem_we = 0, col++. After col == FB_W-1 is issued -> DRAIN.
  - DRAIN: one cycle to capture the final read. Then set swap_pending and go -> IDLE.
  - Read capture: mem_rdata is written to back_buf[col_d], where col_d is the column delayed 1 clk; this is valid in the cycle after each FETCH issue.
- Swap: on av_rise with swap_pending=1, toggle front_sel, front_row = back_row, clear swap_pending.
  - On av_rise while fetch_busy=1: no swap, set underrun; the old front buffer is displayed again.
- Display: pix_rgb is registered and equals front_buf[pix_x>>SHIFT] when available==1, else 0. Latency is 1 clk from pix_x/available.
- Writer arbitration:
  - The writer is served only in IDLE cycles; FETCH/DRAIN starve it. A single FETCH lasts FB_W+1 clks.
  - On a served cycle: mem_addr = wr_addr, mem_wdata = wr_data, mem_we = 1, wr_ack = 1 for exactly that cycle. The requester may issue its next request in the following cycle.
  - wr_addr >= FB_W*FB_H: acked with mem_we = 0 (write discarded).
  - In IDLE, a trigger takes the RAM in the same cycle; that cycle gives no ack and issues the first FETCH address.
- Widths: base uses an ADDR_W-bit product with no overflow by parameter constraint. col is clog2(FB_W) bits. pix_x>>SHIFT values >= FB_W read column FB_W-1.
- underrun clears only on reset.

Test Plan:
- Reset with rst=0 for 3 clks, mid-fetch -> all outputs 0, FSM IDLE, no mem access in the following cycle.
- vs_fall with RAM preloaded so mem[i] = i -> 160 consecutive reads at addrs 0..159, then fetch_busy=0. After the next av_rise, pix_x=8 gives pix_rgb=2 one clk later.
- Line 3 ends (av_fall, pix_y=3) -> fetch of row 1 at addrs 160..319. At pix_y=2 av_fall (target row 0 == front row) -> no fetch.
- Writer holds wr_req during a fetch -> no wr_ack for the fetch duration. Ack arrives 1 clk after DRAIN, with mem_we=1, addr=wr_addr.
- wr_addr=19200 -> wr_ack pulses, mem_we stays 0.
- av_rise forced 50 clks after a fetch trigger -> no swap, underrun=1 and it stays 1. Old row pixels are displayed.
